dac_spi_tx: RTL

SPI write master for the on-board quad 12-bit DAC (LTC2624-class) on the shared SPI bus. It shares the bus with the amplifier/ADC reader. It accepts one channel update per `start` pulse and serialises a 32-bit command word MSB first. It also captures the DAC's SDO echo of the previous word, and holds all other bus devices deselected so the DAC owns the bus.

---
 rtl/dac_spi_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
// SPI write master for a quad 12-bit DAC (LTC2624-class) on a shared SPI bus.
// Each accepted start sends one 32-bit command word {8'h00,cmd,addr,data,4'h0},
// MSB first. At the same time it shifts in the DAC's SDO echo of the previous
// word. The other devices on the bus are held deselected.
//
// Ports
//   clk, enable_n          : system clock, async active-low reset
//   start, cmd, addr, data : write request (sampled on the accept edge only)
//   spi_miso               : DAC SDO
//   busy, done, rx_word    : status, one-cycle completion pulse, SDO echo word
//   dac_cs, spi_sck,
//   spi_mosi, dac_clr      : DAC bus signals
//   amp_cs, sf_ce0,
//   fpga_init_b, spi_ss_b,
//   adc_conv               : constant deselects for the other bus devices
// -----------------------------------------------------------------------------
module dac_spi_tx #(
   parameter int SCK_HALF = 12
) (
   input  logic        clk,
   input  logic        enable_n,
   input  logic        start,
   input  logic [3:0]  cmd,
   input  logic [3:0]  addr,
   input  logic [11:0] data,
   input  logic        spi_miso,
   output logic        busy,
   output logic        done,
   output logic [31:0] rx_word,
   output logic        dac_cs,
   output logic        spi_sck,
   output logic        spi_mosi,
   output logic        dac_clr,
   output logic        amp_cs,
   output logic        sf_ce0,
   output logic        fpga_init_b,
   output logic        spi_ss_b,
   output logic        adc_conv
);

   localparam int DW = $clog2(SCK_HALF);

   localparam logic [2:0] S_CLR     = 3'd0;
   localparam logic [2:0] S_IDLE    = 3'd1;
   localparam logic [2:0] S_SETUP   = 3'd2;
   localparam logic [2:0] S_SHIFT_H = 3'd3;
   localparam logic [2:0] S_SHIFT_L = 3'd4;
   localparam logic [2:0] S_HOLD    = 3'd5;
   localparam logic [2:0] S_GAP     = 3'd6;

   logic [2:0]    r_state;
   logic [DW-1:0] r_div;
   logic [5:0]    r_bitcnt;
   logic [31:0]   r_tx_sr;
   logic [31:0]   r_rx_sr;
   logic [31:0]   r_rx_word;
   logic          r_hold_ph;
   logic          r_busy;
   logic          r_done;
   logic          r_cs;
   logic          r_sck;
   logic          r_clr_n;

   logic          w_tick;
   logic [31:0]   w_frame;

   assign w_tick  = (r_div == DW'(SCK_HALF - 1));
   assign w_frame = {8'h00, cmd, addr, data, 4'h0};

   // MOSI is the top of the transmit register; the register is cleared at the
   // end of a frame so the line idles low.
   assign spi_mosi    = r_tx_sr[31];
   assign busy        = r_busy;
   assign done        = r_done;
   assign rx_word     = r_rx_word;
   assign dac_cs      = r_cs;
   assign spi_sck     = r_sck;
   assign dac_clr     = r_clr_n;

   assign amp_cs      = 1'b1;
   assign sf_ce0      = 1'b1;
   assign fpga_init_b = 1'b1;
   assign spi_ss_b    = 1'b1;
   assign adc_conv    = 1'b0;

   always_ff @(posedge clk or negedge enable_n) begin
      if (!enable_n) begin
         r_state   <= S_CLR;
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_tx_sr   <= '0;
         r_rx_sr   <= '0;
         r_rx_word <= '0;
         r_hold_ph <= 1'b0;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
         r_cs      <= 1'b1;
         r_sck     <= 1'b0;
         r_clr_n   <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Half-period divider free-runs in every state except IDLE, so the
         // first half-period of a frame starts cleanly at the accept edge.
         if (r_state == S_IDLE || w_tick) r_div <= '0;
         else                             r_div <= r_div + DW'(1);

         case (r_state)
            S_CLR: begin
               if (w_tick) begin
                  r_clr_n <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (start) begin
                  r_tx_sr  <= w_frame;
                  r_cs     <= 1'b0;
                  r_busy   <= 1'b1;
                  r_bitcnt <= '0;
                  r_rx_sr  <= '0;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_tick) begin
                  r_sck   <= 1'b1;
                  r_rx_sr <= {r_rx_sr[30:0], spi_miso};
                  r_state <= S_SHIFT_H;
               end
            end
            S_SHIFT_H: begin
               if (w_tick) begin
                  r_sck    <= 1'b0;
                  r_bitcnt <= r_bitcnt + 6'd1;
                  if (r_bitcnt == 6'd31) begin
                     r_hold_ph <= 1'b0;
                     r_state   <= S_HOLD;
                  end else begin
                     r_tx_sr <= {r_tx_sr[30:0], 1'b0};
                     r_state <= S_SHIFT_L;
                  end
               end
            end
            S_SHIFT_L: begin
               if (w_tick) begin
                  r_sck   <= 1'b1;
                  r_rx_sr <= {r_rx_sr[30:0], spi_miso};
                  r_state <= S_SHIFT_H;
               end
            end
            S_HOLD: begin
               // The last bit keeps its full low half-period, then CS stays
               // low one more half-period before the rising edge that makes
               // the DAC execute the command.
               if (w_tick) begin
                  if (!r_hold_ph) begin
                     r_hold_ph <= 1'b1;
                  end else begin
                     r_cs    <= 1'b1;
                     r_tx_sr <= '0;
                     r_state <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  r_done    <= 1'b1;
                  r_rx_word <= r_rx_sr;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_CLR;
               r_busy  <= 1'b1;
               r_clr_n <= 1'b0;
               r_cs    <= 1'b1;
               r_sck   <= 1'b0;
            end
         endcase
      end
   end

endmodule
